// File: rtl/muldiv_ctrl.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        flush,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_r;
    logic        is_div_r;
    logic        neg_a_r;
    logic        neg_b_r;
    logic        b_zero_r;
    logic [31:0] opnd_r;
    logic [31:0] acc_hi_r;
    logic [31:0] acc_lo_r;
    logic [5:0]  cnt_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic [32:0] add_s;
    logic [32:0] shl_s;
    logic [31:0] it_hi_s;
    logic [31:0] it_lo_s;
    logic [63:0] prod_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;
    logic [31:0] mag_rs_s;
    logic [31:0] mag_rt_s;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        logic [31:0] r;
        if (sgn && v[31]) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign busy = (state_r != IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Operand magnitudes, one iteration step, and the final sign correction
    always_comb begin
        mag_rs_s = mag32(rs, op[0]);
        mag_rt_s = mag32(rt, op[0]);
        add_s    = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : 33'd0);
        shl_s    = {acc_hi_r, acc_lo_r[31]};
        if (is_div_r) begin
            // acc_hi holds the partial remainder, acc_lo shifts dividend out and quotient in
            if (shl_s >= {1'b0, opnd_r}) begin
                it_hi_s = shl_s[31:0] - opnd_r;
                it_lo_s = {acc_lo_r[30:0], 1'b1};
            end else begin
                it_hi_s = shl_s[31:0];
                it_lo_s = {acc_lo_r[30:0], 1'b0};
            end
        end else begin
            it_hi_s = add_s[32:1];
            it_lo_s = {add_s[0], acc_lo_r[31:1]};
        end

        if (neg_a_r ^ neg_b_r) begin
            prod_s = 64'd0 - {acc_hi_r, acc_lo_r};
        end else begin
            prod_s = {acc_hi_r, acc_lo_r};
        end

        if (is_div_r) begin
            fix_hi_s = neg_a_r ? (32'd0 - acc_hi_r) : acc_hi_r;
            if (b_zero_r) begin
                fix_lo_s = 32'hFFFF_FFFF;
            end else begin
                fix_lo_s = prod_s[31:0];
            end
        end else begin
            fix_hi_s = prod_s[63:32];
            fix_lo_s = prod_s[31:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO architectural registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            is_div_r <= 1'b0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            b_zero_r <= 1'b0;
            opnd_r   <= 32'd0;
            acc_hi_r <= 32'd0;
            acc_lo_r <= 32'd0;
            cnt_r    <= 6'd0;
            done_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && !flush) begin
                        is_div_r <= op[1];
                        neg_a_r  <= op[0] & rs[31];
                        neg_b_r  <= op[0] & rt[31];
                        b_zero_r <= (rt == 32'd0);
                        opnd_r   <= op[1] ? mag_rt_s : mag_rs_s;
                        acc_hi_r <= 32'd0;
                        acc_lo_r <= op[1] ? mag_rs_s : mag_rt_s;
                        cnt_r    <= 6'd0;
                        state_r  <= RUN;
                    end else begin
                        if (mthi) begin
                            hi_r <= wdata;
                        end
                        if (mtlo) begin
                            lo_r <= wdata;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_r <= IDLE;
                    end else begin
                        acc_hi_r <= it_hi_s;
                        acc_lo_r <= it_lo_s;
                        cnt_r    <= cnt_r + 6'd1;
                        if (cnt_r == 6'd31) begin
                            state_r <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi_r   <= fix_hi_s;
                        lo_r   <= fix_lo_s;
                        done_r <= 1'b1;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 start  in  1  request a new operation; sampled only in IDLE.
REQ-005 op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 rs  in  32  multiplicand or dividend.
REQ-007 rt  in  32  multiplier or divisor.
REQ-008 flush  in  1  abort the in-flight operation (pipeline squash).
REQ-009 mthi, mtlo  in  1 each  direct write of wdata to HI or LO.
REQ-010 wdata  in  32  data for mthi/mtlo.
REQ-011 busy  out  1  operation in progress; pipeline stalls any MFHI/MFLO or new mul/div while busy is high.
REQ-012 done  out  1  one-cycle pulse: HI/LO updated with a new result.
REQ-013 hi, lo  out  32 each  architectural HI/LO registers, feeding the ALU MFHI/MFLO path.

Function
REQ-014 The block SHALL implement states IDLE, RUN and FIX.
REQ-015 IDLE transitions: IDLE with start=1 and flush=0 at edge E0 -> latch op and the operand magnitudes (abs for signed ops), clear the 6-bit iteration counter, go to RUN.
REQ-016 RUN transitions: RUN performs one shift-add (multiply) or one restoring shift-subtract (divide) iteration per cycle; after the 32nd iteration (edge E32) it goes to FIX.
REQ-017 FIX transitions: FIX applies sign correction at edge E33, writes HI/LO, and returns to IDLE; done=1 for exactly the cycle after E33.
REQ-018 busy SHALL be high from the cycle after E0 through the cycle ending at E33; it SHALL be combinationally equal to (state != IDLE).
REQ-019 Multiply SHALL produce the 64-bit product with {hi,lo} = rs*rt; MULT is two's-complement and MULTU is unsigned.
REQ-020 Divide SHALL produce lo = quotient and hi = remainder; the quotient truncates toward zero, its sign is sign(rs) XOR sign(rt), and the remainder takes the sign of rs.
REQ-021 For divide by zero (rt=0), both DIV and DIVU SHALL give hi=rs and lo=0xFFFFFFFF with normal latency and a normal done pulse.
REQ-022 DIV overflow (rs=0x80000000, rt=0xFFFFFFFF) SHALL give lo=0x80000000 and hi=0x00000000.
REQ-023 start asserted while busy SHALL be ignored; there is no queueing.
REQ-024 flush while busy SHALL force IDLE at the next edge; hi/lo keep their pre-operation values and no done is produced.
REQ-025 flush in IDLE together with start SHALL cancel the start.
REQ-026 mthi/mtlo in IDLE with no accepted start SHALL write wdata at the next edge.
REQ-027 mthi/mtlo SHALL be ignored while busy, or in the same cycle as an accepted start.
REQ-028 If mthi and mtlo are both high, both HI and LO SHALL be written.
REQ-029 hi/lo SHALL change only at FIX completion or on an accepted mthi/mtlo.
REQ-030 Operands SHALL be captured at E0; changes to rs/rt/op after E0 SHALL have no effect.

Reset
REQ-031 With rst_n=0 at a rising edge: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and internal accumulators cleared.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no done; the same clear values apply.
REQ-033 The first start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-034 MULTU rs=0xFFFFFFF0, rt=0x7FFFFFF1 -> done 33 cycles after E0; hi=0x7FFFFFE9, lo=0x000000F0; busy high for exactly 33 cycles.
REQ-035 MULT with the same operands -> hi=0xFFFFFFF8, lo=0x000000F0.
REQ-036 DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=100, rt=7 -> lo=0x0000000E, hi=0x00000002.
REQ-037 DIVU rs=0x12345678, rt=0 -> hi=0x12345678, lo=0xFFFFFFFF; DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 mthi wdata=0xA5A5A5A5 in IDLE, then MULTU 3*5 with a second start and an mtlo pulsed mid-run, then flush on cycle 10 -> busy falls next cycle, no done, hi=0xA5A5A5A5, lo unchanged.
REQ-039 MULTU 3*5 with rst_n driven low on cycle 20 -> hi=lo=0, busy=0, done never pulses; a start after rst_n returns high is accepted and completes normally.
